// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the edge window counter: the measurement FSM state
// encoding and the default values of the block parameters.
// -----------------------------------------------------------------------------
package edge_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

  // Default parameter values.
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_WIN_W       = 16;

endpackage : edge_pkg

// File: rtl/edge_sync_detect.sv
// -----------------------------------------------------------------------------
// edge_sync_detect
// Brings an asynchronous level into the clk domain through a flop chain and
// produces registered single-cycle rise/fall pulses.
//
// A level first sampled at edge N is synchronised after edge N+1, compared
// against the previous synchronised value, and the resulting pulse is visible
// in the cycle after edge N+2 (for SYNC_STAGES = 2).
//
// Ports
//   clk     in   clock
//   reset   in   asynchronous active-low reset
//   sig_i   in   asynchronous monitored level
//   rise_o  out  one-cycle pulse on a 0->1 synchronised transition
//   fall_o  out  one-cycle pulse on a 1->0 synchronised transition
// -----------------------------------------------------------------------------
module edge_sync_detect #(
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: every flop here, including the synchroniser chain, is cleared by
  // the asynchronous reset so that a level already high when reset releases
  // is seen as exactly one rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= synced;
      rise_q <= synced & ~prev_q;
      fall_q <= ~synced & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : edge_sync_detect

// File: rtl/edge_window_counter.sv
// -----------------------------------------------------------------------------
// edge_window_counter
// Counts rising and falling edges of an asynchronous signal over a window of
// window_len clock cycles, then presents the saturating counts on a
// valid/ready interface. A new window may be started on the result handshake
// without passing through IDLE.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   reset        in   asynchronous active-low reset
//   sig_in       in   asynchronous monitored signal
//   window_len   in   window length in cycles, sampled when start is accepted
//   start        in   request to begin a window (ignored if window_len == 0)
//   busy         out  high while measuring or holding an unaccepted result
//   count_valid  out  result available
//   count_ready  in   consumer accepts the result
//   pos_count    out  rising edges seen in the last window (saturating)
//   neg_count    out  falling edges seen in the last window (saturating)
//   overflow     out  a counter tried to pass its maximum in the last window
// -----------------------------------------------------------------------------
module edge_window_counter
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned WIN_W       = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic             start,
  output logic             busy,
  output logic             count_valid,
  input  logic             count_ready,
  output logic [CNT_W-1:0] pos_count,
  output logic [CNT_W-1:0] neg_count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] neg_q;
  logic             ovf_q;
  logic             busy_q;
  logic             valid_q;

  logic rise;
  logic fall;
  logic start_ok;

  edge_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_detect (
    .clk   (clk),
    .reset (reset),
    .sig_i (sig_in),
    .rise_o(rise),
    .fall_o(fall)
  );

  // A zero-length window is not a window: such a start request is dropped.
  assign start_ok = start && (window_len != '0);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            pos_q   <= '0;
            neg_q   <= '0;
            ovf_q   <= 1'b0;
            win_q   <= window_len;
            busy_q  <= 1'b1;
            state_q <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          // Saturate rather than wrap; remember that information was lost.
          if (rise) begin
            if (pos_q == CNT_MAX) ovf_q <= 1'b1;
            else                  pos_q <= pos_q + CNT_W'(1);
          end
          if (fall) begin
            if (neg_q == CNT_MAX) ovf_q <= 1'b1;
            else                  neg_q <= neg_q + CNT_W'(1);
          end
          win_q <= win_q - WIN_W'(1);
          // win_q == 1 marks the last measuring cycle; its edges are counted
          // above on this same clock edge.
          if (win_q == WIN_W'(1)) begin
            valid_q <= 1'b1;
            state_q <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          if (count_ready) begin
            valid_q <= 1'b0;
            if (start_ok) begin
              // Back-to-back window: skip IDLE entirely.
              pos_q   <= '0;
              neg_q   <= '0;
              ovf_q   <= 1'b0;
              win_q   <= window_len;
              state_q <= ST_MEASURE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign count_valid = valid_q;
  assign pos_count   = pos_q;
  assign neg_count   = neg_q;
  assign overflow    = ovf_q;

endmodule : edge_window_counter

// File: tb/tb_edge_window_counter.sv
// -----------------------------------------------------------------------------
// tb_edge_window_counter
// Self-checking bench for edge_window_counter with default parameters.
// Every sampled value of sig_in is logged per clock edge; expected counts are
// derived from that log using the detection latency and window timing rules.
// -----------------------------------------------------------------------------
module tb_edge_window_counter;

  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int HIST_N  = 8192;

  localparam int M_RAND = 0;  // random level every cycle
  localparam int M_TOG1 = 1;  // toggle every cycle
  localparam int M_TOG2 = 2;  // toggle every second cycle
  localparam int M_HOLD = 3;  // keep level
  localparam int M_STEP = 4;  // drive 1 at one chosen cycle

  logic             clk = 1'b0;
  logic             reset;
  logic             sig_in;
  logic [WIN_W-1:0] window_len;
  logic             start;
  logic             count_ready;
  logic             busy;
  logic             count_valid;
  logic [CNT_W-1:0] pos_count;
  logic [CNT_W-1:0] neg_count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Edge index bookkeeping: hist[c] is sig_in as sampled at clock edge c.
  int   cyc = 0;
  int   rb  = 0;  // first edge index after the latest reset release
  logic hist [0:HIST_N-1];

  int   last_p;
  int   last_n;
  logic last_o;

  edge_window_counter dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .window_len (window_len),
    .start      (start),
    .busy       (busy),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .pos_count  (pos_count),
    .neg_count  (neg_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cyc < HIST_N) hist[cyc] <= sig_in;
    cyc <= cyc + 1;
  end

  // Level sampled at edge i; anything before the last reset is seen as 0.
  function automatic logic val(input int i);
    if (i < rb || i < 0 || i >= HIST_N) return 1'b0;
    return hist[i];
  endfunction

  // Reference: a transition first sampled at edge t is detected in the cycle
  // after edge t+2. A window accepted at edge e measures the l cycles after
  // edges e .. e+l-1, so transitions sampled at e-2 .. e+l-3 are counted.
  task automatic model(input int e, input int l,
                       output int p, output int n, output logic o);
    int rp = 0;
    int rn = 0;
    for (int t = e - 2; t <= e + l - 3; t++) begin
      if (val(t) && !val(t - 1)) rp++;
      if (!val(t) && val(t - 1)) rn++;
    end
    o = (rp > CNT_MAX) || (rn > CNT_MAX);
    p = (rp > CNT_MAX) ? CNT_MAX : rp;
    n = (rn > CNT_MAX) ? CNT_MAX : rn;
  endtask

  // k counts negedges from the start request; the level set at k is
  // sampled at edge e+k.
  task automatic drive_sig(input int mode, input int k, input int at);
    case (mode)
      M_RAND: sig_in = 1'($urandom);
      M_TOG1: sig_in = ~sig_in;
      M_TOG2: if (k % 2 == 0) sig_in = ~sig_in;
      M_STEP: if (k == at) sig_in = 1'b1;
      default: ;
    endcase
  endtask

  task automatic start_window(input int l, input int mode, input int at,
                              output int e);
    if (mode == M_TOG2) begin
      // First toggle lands two edges ahead of acceptance so that the
      // detector latency lines it up with the first measuring cycle.
      @(negedge clk); sig_in = ~sig_in;
      @(negedge clk);
    end
    @(negedge clk);
    start      = 1'b1;
    window_len = WIN_W'(l);
    e          = cyc;
    drive_sig(mode, 0, at);
  endtask

  task automatic measure(input int e, input int l, input int mode,
                         input int at, input string tag);
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start       = 1'b0;
        count_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || count_valid !== 1'b0 || pos_count !== '0 ||
            neg_count !== '0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL %s window_start: busy=%b valid=%b pos=%0d neg=%0d ovf=%b, required 1 0 0 0 0",
                   tag, busy, count_valid, pos_count, neg_count, overflow);
        end
      end
      window_len = WIN_W'($urandom);  // must not disturb the running window
      drive_sig(mode, k, at);
      if (k == l) begin
        checks++;
        if (busy !== 1'b1 || count_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s last_measure_cycle: busy=%b valid=%b, required busy=1 valid=0",
                   tag, busy, count_valid);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || count_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s report_entry: busy=%b valid=%b, required busy=1 valid=1",
               tag, busy, count_valid);
    end
  endtask

  task automatic check_result(input int e, input int l, input string tag);
    model(e, l, last_p, last_n, last_o);
    checks++;
    if (pos_count !== CNT_W'(last_p) || neg_count !== CNT_W'(last_n) ||
        overflow !== last_o) begin
      errors++;
      $display("FAIL %s result: pos=%0d neg=%0d ovf=%b, required pos=%0d neg=%0d ovf=%b",
               tag, pos_count, neg_count, overflow, last_p, last_n, last_o);
    end
  endtask

  task automatic accept(input string tag);
    @(negedge clk); count_ready = 1'b1;
    @(negedge clk); count_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || count_valid !== 1'b0 || pos_count !== CNT_W'(last_p) ||
        neg_count !== CNT_W'(last_n) || overflow !== last_o) begin
      errors++;
      $display("FAIL %s idle_hold: busy=%b valid=%b pos=%0d neg=%0d ovf=%b, required 0 0 %0d %0d %b",
               tag, busy, count_valid, pos_count, neg_count, overflow,
               last_p, last_n, last_o);
    end
  endtask

  task automatic test_reset();
    int e;
    reset = 1'b0; sig_in = 1'b1; start = 1'b0; count_ready = 1'b0;
    window_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || count_valid !== 1'b0 || pos_count !== '0 ||
        neg_count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b pos=%0d neg=%0d ovf=%b, required all 0",
               busy, count_valid, pos_count, neg_count, overflow);
    end
    // Release with sig_in already high and start a window at once: the
    // high level must appear as exactly one rise.
    @(negedge clk);
    reset = 1'b1; rb = cyc;
    start = 1'b1; window_len = WIN_W'(6); e = cyc;
    measure(e, 6, M_HOLD, 0, "reset_release");
    check_result(e, 6, "reset_release");
    checks++;
    if (pos_count !== CNT_W'(1) || neg_count !== '0) begin
      errors++;
      $display("FAIL reset_release_rise: pos=%0d neg=%0d, required pos=1 neg=0",
               pos_count, neg_count);
    end
    accept("reset_release");
  endtask

  task automatic test_toggle2();
    int e;
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    start_window(10, M_TOG2, 0, e);
    measure(e, 10, M_TOG2, 0, "toggle2");
    check_result(e, 10, "toggle2");
    checks++;
    if (int'(pos_count) + int'(neg_count) != 5 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL toggle2_total: pos+neg=%0d ovf=%b, required 5 and 0",
               int'(pos_count) + int'(neg_count), overflow);
    end
    accept("toggle2");
  endtask

  task automatic test_saturate();
    int e;
    start_window(600, M_TOG1, 0, e);
    measure(e, 600, M_TOG1, 0, "saturate");
    check_result(e, 600, "saturate");
    checks++;
    if (pos_count !== CNT_W'(CNT_MAX) || neg_count !== CNT_W'(CNT_MAX) ||
        overflow !== 1'b1) begin
      errors++;
      $display("FAIL saturate_values: pos=%0d neg=%0d ovf=%b, required 255 255 1",
               pos_count, neg_count, overflow);
    end
    accept("saturate");
  endtask

  task automatic test_random();
    int e;
    int l;
    for (int i = 0; i < 6; i++) begin
      l = int'($urandom_range(1, 40));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_window(l, M_RAND, 0, e);
      measure(e, l, M_RAND, 0, "random");
      check_result(e, l, "random");
      accept("random");
    end
  endtask

  task automatic test_back_to_back();
    int  e;
    bit  bad = 1'b0;
    start_window(8, M_RAND, 0, e);
    measure(e, 8, M_RAND, 0, "stall");
    check_result(e, 8, "stall");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      count_ready = 1'b0;
      start       = 1'(i % 2);  // start without a handshake is ignored
      window_len  = WIN_W'(5);
      sig_in      = 1'($urandom);
      if (count_valid !== 1'b1 || busy !== 1'b1 || pos_count !== CNT_W'(last_p) ||
          neg_count !== CNT_W'(last_n) || overflow !== last_o) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_stable: pos=%0d neg=%0d ovf=%b valid=%b, required %0d %0d %b and valid=1 throughout",
               pos_count, neg_count, overflow, count_valid, last_p, last_n, last_o);
    end
    @(negedge clk);
    count_ready = 1'b1; start = 1'b1; window_len = WIN_W'(12); e = cyc;
    measure(e, 12, M_RAND, 0, "back_to_back");
    check_result(e, 12, "back_to_back");
    accept("back_to_back");
  endtask

  task automatic test_zero_len();
    bit bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0 && (busy !== 1'b0 || count_valid !== 1'b0 ||
          pos_count !== CNT_W'(last_p) || neg_count !== CNT_W'(last_n) ||
          overflow !== last_o)) bad = 1'b1;
      start = 1'b1; window_len = '0; count_ready = 1'b1;
      sig_in = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0; count_ready = 1'b0;
    checks++;
    if (bad || busy !== 1'b0 || count_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_ignored: busy=%b valid=%b pos=%0d, required busy=0 valid=0 pos=%0d",
               busy, count_valid, pos_count, last_p);
    end
  endtask

  task automatic test_last_cycle();
    int e;
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    start_window(8, M_STEP, 5, e);  // detected in the 8th measuring cycle
    measure(e, 8, M_STEP, 5, "last_cycle");
    check_result(e, 8, "last_cycle");
    checks++;
    if (pos_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL last_cycle_rise: pos=%0d, required 1", pos_count);
    end
    accept("last_cycle");
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    start_window(8, M_STEP, 6, e);  // detected one cycle after the window
    measure(e, 8, M_STEP, 6, "after_window");
    check_result(e, 8, "after_window");
    checks++;
    if (pos_count !== '0) begin
      errors++;
      $display("FAIL after_window_rise: pos=%0d, required 0", pos_count);
    end
    accept("after_window");
  endtask

  task automatic test_reset_mid();
    int e;
    bit bad = 1'b0;
    start_window(10, M_RAND, 0, e);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      sig_in = 1'($urandom);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || count_valid !== 1'b0 || pos_count !== '0 ||
        neg_count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_window: busy=%b valid=%b pos=%0d neg=%0d ovf=%b, required all 0",
               busy, count_valid, pos_count, neg_count, overflow);
    end
    @(negedge clk);
    reset = 1'b1; rb = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      count_ready = 1'b1;
      if (count_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    count_ready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_no_result: valid=%b busy=%b, required 0 0 after reset",
               count_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_toggle2();
    test_saturate();
    test_random();
    test_back_to_back();
    test_zero_len();
    test_last_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_edge_window_counter

// File: doc/edge_window_counter.md
EDGE_WINDOW_COUNTER -- requirements
Module: edge_window_counter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on sig_in (minimum 2).
REQ-002 Parameter CNT_W, default 8, width of the edge counters.
REQ-003 Parameter WIN_W, default 16, width of the window length.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sig_in  input  1  asynchronous monitored signal.
REQ-007 window_len  input  WIN_W  measurement window in clk cycles, sampled on start acceptance.
REQ-008 start  input  1  request to begin a window.
REQ-009 busy  output  1  high in MEASURE or REPORT.
REQ-010 count_valid  output  1  result available.
REQ-011 count_ready  input  1  consumer accepts result.
REQ-012 pos_count  output  CNT_W  rising edges in last window.
REQ-013 neg_count  output  CNT_W  falling edges in last window.
REQ-014 overflow  output  1  either counter saturated during last window.

Function
REQ-015 sig_in SHALL pass through SYNC_STAGES flops; a prev register SHALL hold the previous synchronised value, updated every cycle in all states.
REQ-016 Rise = synced 1 and prev 0; fall = synced 0 and prev 1; with SYNC_STAGES=2 a sig_in transition before clock edge N SHALL be detected in the cycle after edge N+2.
REQ-017 FSM states SHALL be IDLE, MEASURE, REPORT.
REQ-018 IDLE: start=1 with window_len!=0 SHALL clear pos/neg counters and overflow, load the window down-counter with window_len, and enter MEASURE next cycle.
REQ-019 IDLE: start=1 with window_len=0 SHALL be ignored.
REQ-020 MEASURE: each cycle, a detected rise SHALL increment pos_count and a fall SHALL increment neg_count; the window counter SHALL decrement.
REQ-021 Counters SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set overflow, which stays set until the next window starts.
REQ-022 MEASURE SHALL last exactly window_len cycles; edges detected in the last cycle SHALL be counted; then enter REPORT.
REQ-023 REPORT: count_valid=1; pos_count, neg_count and overflow SHALL stay stable until count_valid and count_ready are both high.
REQ-024 On the handshake with start=1 and window_len!=0, the block SHALL enter MEASURE directly, with no IDLE cycle; otherwise it SHALL enter IDLE.
REQ-025 start in MEASURE or REPORT, except as in REQ-024, SHALL be ignored; window_len changes during MEASURE SHALL have no effect.
REQ-026 In IDLE, outputs SHALL hold the last reported values; count_valid SHALL be 0.
REQ-027 count_ready while count_valid=0 SHALL have no effect.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, synchroniser and prev to 0, counters, overflow, window counter, busy and count_valid to 0.
REQ-029 Reset asserted mid-window SHALL discard the window; no result SHALL be reported.
REQ-030 After deassertion, sig_in already high SHALL appear as one rise, counted only if a window is active.

Structure
REQ-031 FSM state enum and default parameter constants SHALL live in a shared package, edge_pkg.
REQ-032 The synchroniser plus rise/fall detector SHALL be a sub-module, edge_sync_detect, outputs rise and fall pulses.

Verification
REQ-033 window_len=10, sig_in toggles every 2 cycles from window start -> pos_count+neg_count=5 and matches the synced phase; overflow=0.
REQ-034 window_len=600, sig_in toggles every cycle -> pos_count=255, neg_count=255, overflow=1.
REQ-035 count_ready held 0 for 20 cycles in REPORT -> outputs stable, count_valid=1 throughout; handshake with start=1 -> MEASURE on the next cycle, counters 0.
REQ-036 start=1 with window_len=0 -> stays IDLE, busy=0.
REQ-037 reset pulsed low at cycle 5 of a 10-cycle window -> busy=0, count_valid=0, counters 0 immediately; no result reported.
REQ-038 Single rise placed in the last MEASURE cycle -> pos_count=1; rise detected one cycle after MEASURE ends -> not counted.
